bus_timer: RTL

Memory-mapped programmable timer that sits on the shared system bus as a slave/responder. It answers read and write transfers issued by the CPU bus masters (instruction and data ports) with a configurable wait-state handshake. It counts clock cycles against a programmable expiry value and raises a level interrupt that the interrupt controller routes into the CPU IRQ vector.

---
 rtl/bus_timer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// bus_timer: bus-attached programmable timer with a wait-state handshake.
// Registers: CTRL (Start/Periodic), INTR (IRQ status), EXPR (expiry), COUNT.
// A transfer is accepted in IDLE, optionally held in WAIT, then answered in ACK.
// Read data and Rdy_ are registered: they are computed from the next-state
// register values so that a read shows the register as it is during ACK.
module bus_timer #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        BusCS_,
  input  logic        BusAs_,
  input  logic [1:0]  BusAddr,
  input  logic        BusRW,
  input  logic [31:0] BusWrData,
  output logic [31:0] BusRdData,
  output logic        BusRdy_,
  output logic        IRQ
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} busState_t;

  busState_t   state;
  busState_t   nextState;
  logic [3:0]  waitCnt;
  logic [3:0]  waitCntNext;

  logic [1:0]  capAddr;
  logic        capRW;
  logic [31:0] capWrData;

  logic [1:0]  ctrlReg;
  logic [1:0]  ctrlNext;
  logic        intrReg;
  logic        intrNext;
  logic [31:0] exprReg;
  logic [31:0] exprNext;
  logic [31:0] countReg;
  logic [31:0] countNext;

  logic        accept;
  logic        expire;
  logic        wrCommit;
  logic [1:0]  rdSel;
  logic        rdIsRead;
  logic [31:0] rdValue;

  assign accept   = (state == IDLE) && !BusCS_ && !BusAs_;
  assign expire   = ctrlReg[0] && (countReg == exprReg);
  assign wrCommit = (state == ACK) && !capRW;
  assign IRQ      = intrReg;

  // Bus FSM state and wait-state down-counter registers
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
    end
  end

  // Bus FSM next-state: accept in IDLE, count down in WAIT, single-cycle ACK
  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          waitCntNext = WaitLoad;
          nextState   = (WaitLoad != 4'd0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        waitCntNext = waitCnt - 4'd1;
        if (waitCnt <= 4'd1) begin
          nextState = ACK;
        end
      end
      ACK: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Capture the transfer attributes on the accept edge
  always_ff @(posedge clk) begin
    if (!reset_) begin
      capAddr   <= 2'd0;
      capRW     <= 1'b0;
      capWrData <= 32'd0;
    end else if (accept) begin
      capAddr   <= BusAddr;
      capRW     <= BusRW;
      capWrData <= BusWrData;
    end
  end

  // Timer next values; bus writes are applied last so they override the counter
  always_comb begin
    ctrlNext  = ctrlReg;
    intrNext  = intrReg;
    exprNext  = exprReg;
    countNext = countReg;
    if (ctrlReg[0]) begin
      if (expire) begin
        countNext = 32'd0;
        intrNext  = 1'b1;
        if (!ctrlReg[1]) begin
          ctrlNext[0] = 1'b0;
        end
      end else begin
        countNext = countReg + 32'd1;
      end
    end
    if (wrCommit) begin
      case (capAddr)
        2'd0:    ctrlNext  = capWrData[1:0];
        2'd1:    intrNext  = expire;
        2'd2:    exprNext  = capWrData;
        default: countNext = capWrData;
      endcase
    end
  end

  // Timer register update
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ctrlReg  <= 2'd0;
      intrReg  <= 1'b0;
      exprReg  <= 32'd0;
      countReg <= 32'd0;
    end else begin
      ctrlReg  <= ctrlNext;
      intrReg  <= intrNext;
      exprReg  <= exprNext;
      countReg <= countNext;
    end
  end

  // Select read data from next-cycle register values for the transfer entering ACK
  always_comb begin
    rdSel    = (state == IDLE) ? BusAddr : capAddr;
    rdIsRead = (state == IDLE) ? BusRW : capRW;
    rdValue  = 32'd0;
    case (rdSel)
      2'd0:    rdValue = {30'd0, ctrlNext};
      2'd1:    rdValue = {31'd0, intrNext};
      2'd2:    rdValue = exprNext;
      default: rdValue = countNext;
    endcase
  end

  // Registered bus outputs: Rdy_ low and read data valid only during ACK
  always_ff @(posedge clk) begin
    if (!reset_) begin
      BusRdy_   <= 1'b1;
      BusRdData <= 32'd0;
    end else begin
      BusRdy_   <= (nextState != ACK);
      BusRdData <= ((nextState == ACK) && rdIsRead) ? rdValue : 32'd0;
    end
  end

endmodule
